// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the unified-memory arbiter.
//   arb_state_t : arbiter FSM states
//   REQ_ID_I/D  : requester identifiers for trace output
//   WORD_W      : default data/address width
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_I  = 3'd1,
    REQ_D  = 3'd2,
    WAIT_I = 3'd3,
    WAIT_D = 3'd4
  } arb_state_t;

  localparam logic REQ_ID_I = 1'b0;
  localparam logic REQ_ID_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch (I), memory-stage (D) and memory-side
// signals of the arbiter.
//   slave  : the arbiter's view (takes requests, drives memory)
//   master : the environment's view (pipeline stages plus memory model)
interface mem_arbiter_if #(
  parameter int WORD = 32
);
  // Fetch requester
  logic            i_req;
  logic [WORD-1:0] i_addr;
  logic [WORD-1:0] i_rdata;
  logic            i_valid;
  // Data requester
  logic            d_req;
  logic            d_we;
  logic [WORD-1:0] d_addr;
  logic [WORD-1:0] d_wdata;
  logic [3:0]      d_wmask;
  logic [WORD-1:0] d_rdata;
  logic            d_valid;
  // Memory side
  logic            mem_req;
  logic            mem_we;
  logic [WORD-1:0] mem_addr;
  logic [WORD-1:0] mem_wdata;
  logic [3:0]      mem_wmask;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [WORD-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask,
           mem_ready, mem_rvalid, mem_rdata,
    output i_rdata, i_valid, d_rdata, d_valid,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask,
           mem_ready, mem_rvalid, mem_rdata,
    input  i_rdata, i_valid, d_rdata, d_valid,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/starve_counter.sv
// starve_counter: saturating counter of cycles the fetch requester has been
// waiting without being served.
//   clk, reset : clock, asynchronous active-low reset
//   inc        : count one more waiting cycle (ignored once at MAX_WAIT)
//   clr        : clear to zero (wins over inc)
//   cnt        : current count
//   at_max     : cnt has reached MAX_WAIT
module starve_counter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  assign at_max = (cnt == CNT_W'(MAX_WAIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch stage (I,
// read-only) and the memory stage (D, read/write). One transaction in flight
// at a time; D has priority unless I has lost MAX_WAIT consecutive cycles.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave -- I/D request/response and memory port
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int WORD     = WORD_W,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  arb_state_t state, state_nxt;
  logic       cancel, cancel_nxt;
  logic       grant_i, grant_d;
  logic       req, i_vld, d_vld;

  logic [WORD-1:0] addr_q, wdata_q;
  logic            we_q;
  logic [3:0]      wmask_q;

  logic [CNT_W-1:0] wait_cnt;
  logic             at_max;
  logic             cnt_inc, cnt_clr;

  // I is waiting whenever it requests but is not the one being served.
  assign cnt_inc = bus.i_req && (state != REQ_I) && (state != WAIT_I);
  assign cnt_clr = grant_i || !bus.i_req;

  starve_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .cnt    (wait_cnt),
    .at_max (at_max)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cancel <= 1'b0;
    end else begin
      state  <= state_nxt;
      cancel <= cancel_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cancel_nxt = 1'b0;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    req        = 1'b0;
    i_vld      = 1'b0;
    d_vld      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_req && !(bus.i_req && at_max)) begin
          grant_d   = 1'b1;
          state_nxt = REQ_D;
        end else if (bus.i_req) begin
          grant_i   = 1'b1;
          state_nxt = REQ_I;
        end
      end
      REQ_I: begin
        // A fetch flush withdraws the request before memory accepts it.
        if (!bus.i_req) begin
          state_nxt = IDLE;
        end else begin
          req = 1'b1;
          if (bus.mem_ready) state_nxt = WAIT_I;
        end
      end
      REQ_D: begin
        req = 1'b1;
        if (bus.mem_ready) state_nxt = WAIT_D;
      end
      WAIT_I: begin
        // The response must still be consumed after a flush, but it is
        // swallowed rather than handed to a fetch stage that moved on.
        if (bus.mem_rvalid) begin
          i_vld     = bus.i_req && !cancel;
          state_nxt = IDLE;
        end else begin
          cancel_nxt = cancel || !bus.i_req;
        end
      end
      WAIT_D: begin
        if (bus.mem_rvalid) begin
          d_vld     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured at grant so the memory sees stable values
  // however long mem_ready stays low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      wmask_q <= 4'b0;
    end else if (grant_d) begin
      addr_q  <= bus.d_addr;
      wdata_q <= bus.d_wdata;
      we_q    <= bus.d_we;
      wmask_q <= bus.d_wmask;
    end else if (grant_i) begin
      addr_q  <= bus.i_addr;
      wdata_q <= '0;
      we_q    <= 1'b0;
      wmask_q <= 4'b0;
    end
  end

  assign bus.mem_req   = req;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wmask = wmask_q;

  assign bus.i_valid = i_vld;
  assign bus.d_valid = d_vld;
  assign bus.i_rdata = i_vld ? bus.mem_rdata : '0;
  assign bus.d_rdata = d_vld ? bus.mem_rdata : '0;

endmodule
